// File: rtl/dmem_cache.sv
// Data-side memory stage: direct-mapped, write-through, no-write-allocate
// cache with 4-word lines and a single-outstanding req/ack backing port.
module dmem_cache #(
    parameter int unsigned SETS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memReadM,
    input  logic        memWriteM,
    input  logic [31:0] addrM,
    input  logic [31:0] writeDataM,
    input  logic [2:0]  addressingmodeM,
    output logic [31:0] readDataM,
    output logic        stallM,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memWstrb,
    input  logic [31:0] memRdata,
    input  logic        memAck
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

    state_t state, state_next;
    logic [1:0] cnt, cnt_next;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS][4];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       word;
    logic [31:0]      cached_word;
    logic             hit;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] store_wdata;
    logic [3:0]  store_strb;
    logic [31:0] merge_word;

    logic stall_c;
    logic fill_we;
    logic fill_last;
    logic merge_we;
    logic inval;

    assign idx         = addrM[IDX_W+3:4];
    assign tag         = addrM[31:IDX_W+4];
    assign word        = addrM[3:2];
    assign cached_word = data[idx][word];
    assign hit         = valid[idx] && (tags[idx] == tag);

    // Load extension of the addressed word by funct3
    always_comb begin
        byte_sel = 8'(cached_word >> {addrM[1:0], 3'b000});
        half_sel = addrM[1] ? cached_word[31:16] : cached_word[15:0];
        case (addressingmodeM)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = cached_word;
        endcase
    end

    // Hit data is only presented for a load resolving in IDLE
    assign readDataM = (state == IDLE && memReadM && !memWriteM && hit) ? load_ext : 32'h0;

    // Store byte-lane positioning and strobes
    always_comb begin
        store_wdata = writeDataM;
        store_strb  = 4'b1111;
        case (addressingmodeM[1:0])
            2'b00: begin
                store_wdata = 32'(writeDataM[7:0]) << {addrM[1:0], 3'b000};
                store_strb  = 4'b0001 << addrM[1:0];
            end
            2'b01: begin
                store_wdata = addrM[1] ? {writeDataM[15:0], 16'h0} : {16'h0, writeDataM[15:0]};
                store_strb  = addrM[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Strobed bytes merged into the cached word on a store hit
    always_comb begin
        merge_word = cached_word;
        for (int b = 0; b < 4; b++) begin
            if (memWstrb[b]) merge_word[8*b +: 8] = memWdata[8*b +: 8];
        end
    end

    // State and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state, backing-port decode and array write enables
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_c    = 1'b0;
        memReq     = 1'b0;
        memWe      = 1'b0;
        memAddr    = 32'h0;
        memWdata   = 32'h0;
        memWstrb   = 4'b0000;
        fill_we    = 1'b0;
        fill_last  = 1'b0;
        merge_we   = 1'b0;
        inval      = 1'b0;
        case (state)
            IDLE: begin
                if (memWriteM) begin
                    stall_c    = 1'b1;
                    state_next = WRITE;
                end else if (memReadM && !hit) begin
                    stall_c    = 1'b1;
                    inval      = 1'b1;
                    cnt_next   = 2'd0;
                    state_next = REFILL;
                end
            end
            REFILL: begin
                stall_c = 1'b1;
                memReq  = 1'b1;
                memAddr = {addrM[31:4], cnt, 2'b00};
                if (memAck) begin
                    fill_we  = 1'b1;
                    cnt_next = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        fill_last  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WRITE: begin
                stall_c  = 1'b1;
                memReq   = 1'b1;
                memWe    = 1'b1;
                memAddr  = {addrM[31:2], 2'b00};
                memWdata = store_wdata;
                memWstrb = store_strb;
                if (memAck) begin
                    merge_we   = hit;
                    state_next = WDONE;
                end
            end
            WDONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign stallM = stall_c && !rst;

    // Valid bits: cleared at refill start so an aborted fill never hits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (fill_last) begin
            valid[idx] <= 1'b1;
        end else if (inval) begin
            valid[idx] <= 1'b0;
        end
    end

    // Tag and data arrays
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data[idx][cnt] <= memRdata;
        end else if (merge_we) begin
            data[idx][word] <= merge_word;
        end
        if (fill_last) begin
            tags[idx] <= tag;
        end
    end
endmodule
